key_debounce_pulse: RTL and testbench



---
 rtl/key_debounce_pulse.sv | 219 +++++++++++++++++++++
 tb/tb_key_debounce_pulse.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_pulse
// Description : Conditions a raw active-low pushbutton into a debounced level
//               and a single-cycle enable pulse for downstream counters.
//               2-flop synchroniser -> debounce FSM with qualification counter
//               -> optional auto-repeat generator.
//
// Optional feature macro : KEY_AUTO_REPEAT_EN
//     defined   - while the key is held, extra pulses fire after REPEAT_DELAY
//                 cycles and then every REPEAT_RATE cycles.
//     undefined - exactly one pulse per accepted press.
//
// Ports:
//     clock    in   system clock, rising edge
//     reset    in   synchronous active-high reset
//     key_n    in   raw pushbutton, 0 = pressed, asynchronous to clock
//     pressed  out  debounced level, 1 while the button is accepted as held
//     pulse    out  one-cycle enable per accepted press (plus repeats)
//
// Revision    : 1.0  initial release
// ============================================================================
module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic pulse
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce_pulse: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_repeat
        $error("key_debounce_pulse: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end
    if ((longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_width
        $error("key_debounce_pulse: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ZERO     = '0;
    localparam logic [CNT_W-1:0] c_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Synchroniser: both stages reset to "released" so that a key still
    // held through reset is seen as a fresh 1->0 transition.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic key_s_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            key_s_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pressed_q, pressed_d;
    logic             pulse_q,   pulse_d;
    logic             w_press_pulse;
    logic             w_rep_pulse;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pressed_d     = pressed_q;
        w_press_pulse = 1'b0;

        case (state_q)
            S_IDLE: begin
                pressed_d = 1'b0;
                if (!key_s_q) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = c_ZERO;
                end
            end

            S_PRESS_WAIT: begin
                if (key_s_q) begin
                    // Any disagreement restarts qualification from scratch.
                    state_d = S_IDLE;
                    cnt_d   = c_ZERO;
                end else if (cnt_q == c_DEB_LAST) begin
                    state_d       = S_HELD;
                    cnt_d         = c_ZERO;
                    pressed_d     = 1'b1;
                    w_press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end

            S_HELD: begin
                if (key_s_q) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = c_ZERO;
                end
            end

            S_RELEASE_WAIT: begin
                if (!key_s_q) begin
                    // Release bounce: back to HELD silently, no new pulse.
                    state_d = S_HELD;
                    cnt_d   = c_ZERO;
                end else if (cnt_q == c_DEB_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = c_ZERO;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                cnt_d     = c_ZERO;
                pressed_d = 1'b0;
            end
        endcase
    end

`ifdef KEY_AUTO_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat: rcnt runs only while in HELD. The first period is
    // REPEAT_DELAY, subsequent periods are REPEAT_RATE. It freezes in
    // RELEASE_WAIT so a release bounce does not restart the delay.
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_RR_LAST = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] rcnt_q,   rcnt_d;
    logic             rfirst_q, rfirst_d;
    logic             w_enter_held;
    logic [CNT_W-1:0] w_rlimit;

    assign w_enter_held = (state_q == S_PRESS_WAIT) && (state_d == S_HELD);
    assign w_rlimit     = rfirst_q ? c_RD_LAST : c_RR_LAST;

    always_comb begin
        rcnt_d      = rcnt_q;
        rfirst_d    = rfirst_q;
        w_rep_pulse = 1'b0;

        if (w_enter_held) begin
            rcnt_d   = c_ZERO;
            rfirst_d = 1'b1;
        end else if (state_q == S_HELD) begin
            if (rcnt_q == w_rlimit) begin
                w_rep_pulse = 1'b1;
                rcnt_d      = c_ZERO;
                rfirst_d    = 1'b0;
            end else begin
                rcnt_d = rcnt_q + c_ONE;
            end
        end else if (state_q == S_IDLE) begin
            rcnt_d   = c_ZERO;
            rfirst_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rcnt_q   <= c_ZERO;
            rfirst_q <= 1'b1;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
        end
    end
`else
    assign w_rep_pulse = 1'b0;
`endif

    assign pulse_d = w_press_pulse | w_rep_pulse;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= c_ZERO;
            pressed_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pressed = pressed_q;
    assign pulse   = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_pulse
// Description : Directed self-checking bench for key_debounce_pulse with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, CNT_W=8.
//               Expected pulse edges depend on KEY_AUTO_REPEAT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_key_debounce_pulse;

    logic clock;
    logic reset;
    logic key_n;
    logic pressed;
    logic pulse;

    int n_tests;
    int n_fail;

    // Stimulus/expectation tables for one run window.
    // key_q[e-1] is the key_n value sampled at edge e (last value repeats).
    bit key_q[$];
    int pulse_q[$];

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .CNT_W           (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .key_n   (key_n),
        .pressed (pressed),
        .pulse   (pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int edge_no, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, edge_no, obs, exp);
        end
    endtask

    // Runs n edges. pressed starts at p0, rises at edge 'rise' (0 = never),
    // falls at edge 'fall' (0 = never); pulse expected exactly at pulse_q edges.
    task automatic run(input string tag, input int n, input logic p0, input int rise, input int fall);
        logic exp_pr;
        logic exp_pu;
        for (int e = 1; e <= n; e++) begin
            key_n = (e - 1 < key_q.size()) ? key_q[e-1] : key_q[key_q.size()-1];
            tick();
            exp_pr = p0;
            if (rise > 0 && e >= rise) exp_pr = 1'b1;
            if (fall > 0 && e >= fall) exp_pr = 1'b0;
            exp_pu = 1'b0;
            foreach (pulse_q[i]) if (pulse_q[i] == e) exp_pu = 1'b1;
            chk({tag, ".pressed"}, e, pressed, exp_pr);
            chk({tag, ".pulse"},   e, pulse,   exp_pu);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        key_n   = 1'b0;

        // 1. Reset with key held, then release reset with key still held.
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("t1_reset.pressed", e, pressed, 1'b0);
            chk("t1_reset.pulse",   e, pulse,   1'b0);
        end
        reset = 1'b0;
        key_q = '{1'b0};   pulse_q = '{7};
        run("t1_press", 10, 1'b0, 7, 0);
        key_q = '{1'b1};   pulse_q = '{};
        run("t1_release", 8, 1'b1, 0, 7);

        // 2. Clean press held 20 cycles, then release at edge 21.
        key_q = {};
        for (int i = 0; i < 20; i++) key_q.push_back(1'b0);
        key_q.push_back(1'b1);
`ifdef KEY_AUTO_REPEAT_EN
        pulse_q = '{7, 17, 20, 23};
`else
        pulse_q = '{7};
`endif
        run("t2_clean", 28, 1'b0, 7, 27);

        // 3. Press bounce: 0,0,1,0,1 then steady 0.
        key_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        pulse_q = '{12};
        run("t3_bounce", 16, 1'b0, 12, 0);
        key_q = '{1'b1};   pulse_q = '{};
        run("t3_release", 8, 1'b1, 0, 7);

        // 4. Release bounce while held: 1,1 then 0 for 10.
        key_q = '{1'b0};   pulse_q = '{7};
        run("t4_press", 10, 1'b0, 7, 0);
        key_q = '{1'b1, 1'b1, 1'b0};
`ifdef KEY_AUTO_REPEAT_EN
        pulse_q = '{9, 12};
`else
        pulse_q = '{};
`endif
        run("t4_rbounce", 12, 1'b1, 0, 0);
        // Full debounce time before pressed falls proves the FSM was in HELD.
        key_q = '{1'b1};
`ifdef KEY_AUTO_REPEAT_EN
        pulse_q = '{3};
`else
        pulse_q = '{};
`endif
        run("t4_release", 8, 1'b1, 0, 7);

        // 5. Key held 30 cycles (auto-repeat window).
        key_q = '{1'b0};
`ifdef KEY_AUTO_REPEAT_EN
        pulse_q = '{7, 17, 20, 23, 26, 29};
`else
        pulse_q = '{7};
`endif
        run("t5_hold", 30, 1'b0, 7, 0);
        key_q = '{1'b1};
`ifdef KEY_AUTO_REPEAT_EN
        pulse_q = '{2};
`else
        pulse_q = '{};
`endif
        run("t5_release", 8, 1'b1, 0, 7);

        // 6. One-edge reset during HELD with key held.
        key_q = '{1'b0};   pulse_q = '{7};
        run("t6_press", 9, 1'b0, 7, 0);
        reset = 1'b1;
        tick();
        chk("t6_reset.pressed", 1, pressed, 1'b0);
        chk("t6_reset.pulse",   1, pulse,   1'b0);
        reset = 1'b0;
        key_q = '{1'b0};   pulse_q = '{7};
        run("t6_repress", 9, 1'b0, 7, 0);
        key_q = '{1'b1};   pulse_q = '{};
        run("t6_release", 8, 1'b1, 0, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
